// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder: slice width and controller state codes.
package nibble_serial_adder_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_ctrl_add4.sv
// 4-bit ripple-carry adder slice, time-shared by the nibble-serial controller.
module add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic       co,
  output logic [3:0] s
);

  logic [4:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < 4; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[4];
  end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide adder built by sequencing one add4 slice over NIBBLES cycles, LS nibble first,
// behind a start/done handshake.
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   ci,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   s,
  output logic                   co
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic [W-1:0]       a_sh;
  logic [W-1:0]       b_sh;
  logic [W-1:0]       partial;
  logic [W-1:0]       partial_nxt;
  logic [NIBBLE_W-1:0] nib_s;
  logic               nib_co;

  add4 u_add4 (
    .a  (a_sh[NIBBLE_W-1:0]),
    .b  (b_sh[NIBBLE_W-1:0]),
    .ci (carry),
    .co (nib_co),
    .s  (nib_s)
  );

  // Each new slice sum enters at the top; after NIBBLES shifts the LS nibble sits at bit 0.
  assign partial_nxt = {nib_s, partial[W-1:NIBBLE_W]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      idx     <= '0;
      carry   <= 1'b0;
      a_sh    <= '0;
      b_sh    <= '0;
      partial <= '0;
      s       <= '0;
      co      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sh    <= a;
            b_sh    <= b;
            carry   <= ci;
            idx     <= '0;
            partial <= '0;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          carry   <= nib_co;
          a_sh    <= a_sh >> NIBBLE_W;
          b_sh    <= b_sh >> NIBBLE_W;
          partial <= partial_nxt;
          if (idx == LAST_IDX) begin
            idx   <= '0;
            s     <= partial_nxt;
            co    <= nib_co;
            state <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule
